qtree_int_stream_tx: RTL and testbench
======================================

# qtree_int_stream_tx

Serializes a `QTree_Int` structure resident in the accelerator heap back to the host as an AXI-stream of tokens. It sits on the output side of the QTree benchmarks, downstream of the heap's read port. It emits the same postfix token format that the input-side deserializer consumes, so a tree streamed out can be streamed back in unchanged. A root pointer starts a traversal. The block reads heap words, walks the tree depth-first, and emits one token per node with `tlast` on the final token.

## Interface
Parameters:
- `ADDR_W`, 16, heap address width (pointer payload bits).
- `STACK_DEPTH`, 256, entries in the traversal stack (power of two).

Ports:
- `clk`  in  1  single clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `root_d`  in  ADDR_W+1  root pointer; bit 0 valid, `[ADDR_W:1]` address.
- `root_r`  out  1  root accepted (ready).
- `rd_addr_d`  out  ADDR_W+1  heap read request; bit 0 valid, `[ADDR_W:1]` address.
- `rd_addr_r`  in  1  heap accepts request.
- `rd_data_d`  in  67  heap word (`QTree_Int_t`); bit 0 valid.
- `rd_data_r`  out  1  ready for heap word.
- `o_QTree_Int_tdata`  out  67  token.
- `o_QTree_Int_tlast`  out  1  last token of tree.
- `o_QTree_Int_tvalid`  out  1  token valid.
- `o_QTree_Int_tready`  in  1  host ready.
- `overflow`  out  1  sticky traversal-stack overflow.
- `busy`  out  1  traversal in progress.

## Operation
Word format (`QTree_Int_t`):
- `[2:1]` tag: 0 QNone, 1 QVal, 2 QNode, 3 QError.
- QVal: 32-bit int at `[34:3]`.
- QNode: child pointers c0..c3 at `[18:3]`, `[34:19]`, `[50:35]`, `[66:51]`.

Token emission:
- Postfix order: c0 subtree, c1 subtree, c2 subtree, c3 subtree, then the node's own token.
- Leaf tokens (tags 0/1/3) are the heap word verbatim with bit 0 forced to 1.
- QNode token is `{64'd0, 2'd2, 1'b1}`; child pointers are not transmitted.

Stack:
- Entries are `{marker, addr}`.
- `marker=1` means "emit QNode token".

FSM:
- IDLE: `root_r`=1. On `root_d[0]`=1, push `{0, root addr}` → POP.
- POP: stack empty → IDLE. Otherwise pop; marker → EMIT (QNode token), else latch addr → RD_REQ.
- RD_REQ: drive `rd_addr_d` valid; on `rd_addr_r` → RD_WAIT.
- RD_WAIT: `rd_data_r`=1. On `rd_data_d[0]`: tag 2 → PUSH, else → EMIT with the leaf token.
- PUSH: 5 cycles, one push per cycle, in the order marker, c3, c2, c1, c0 (c0 on top) → POP.
- EMIT: hold token with `tvalid`=1. `tlast` = (stack empty). On `tready` → POP.

Overflow:
- A push when the stack is full sets `overflow`.
- The FSM then clears the stack and returns to IDLE immediately; no `tlast` is emitted for that tree.
- `overflow` clears only on reset.

Other rules:
- `root_d` is ignored outside IDLE.
- `busy` = (state != IDLE).

## Timing
Reset values (async assert, sync deassert):
- `root_r`=0 during reset, 1 in the first cycle after reset.
- All `_d` bit 0, `tvalid`, `tlast`, `overflow`, `busy` = 0.
- Stack pointer = 0.

Reset mid-traversal: all state is abandoned, no further tokens are emitted, and the next root is accepted normally.

Latency:
- Root accept → first `rd_addr_d` valid: 2 cycles (IDLE→POP→RD_REQ).
- Leaf root, zero-wait heap: token valid 2 cycles after `rd_addr_r` handshake.

Handshake rules:
- Outputs are registered.
- `tdata`/`tlast` are stable while `tvalid`=1 and `tready`=0.
- `rd_addr_d` is held until `rd_addr_r`.

Stack:
- Full = STACK_DEPTH entries. Pointer width is log2(STACK_DEPTH)+1, so full and empty are distinct.
- No wrap-around.

Simultaneous events: `tready` in the same cycle `tvalid` rises completes the transfer; the next token is no earlier than 2 cycles later.

## Test plan
- Leaf root: heap[5]=QVal 42, root=5 → one token tag 1, int 42, `tlast`=1; FSM returns to IDLE.
- One QNode: heap[1]=QNode(2,3,4,5), heap[2..5]=QVal 10,11,12,13 → tokens 10,11,12,13,QNode; `tlast` only on QNode.
- Two-level tree (c0 is a QNode of four QNone) → 9 tokens in postfix order. Feeding them back through the input deserializer rebuilds an equal tree.
- Random `tready` stalls and 0-3 cycle heap latency on the two-level tree → identical token sequence; no `tdata` change while stalled.
- STACK_DEPTH=4 with a single QNode root → `overflow`=1; no `tlast`; IDLE; next leaf root still streams correctly.
- `aresetn` pulsed low mid-stream during the one-QNode case → outputs reset immediately; a new root emits a complete, correct stream.

Source files
------------

// File: rtl/qtree_int_stream_tx.sv
// qtree_int_stream_tx: walks a QTree_Int in the heap depth-first and streams it
// out as postfix tokens (children c0..c3, then the node), tlast on the final token.
module qtree_int_stream_tx #(
   parameter int ADDR_W      = 16,
   parameter int STACK_DEPTH = 256
) (
   input  logic              clk,
   input  logic              aresetn,
   input  logic [ADDR_W:0]   root_d,
   output logic              root_r,
   output logic [ADDR_W:0]   rd_addr_d,
   input  logic              rd_addr_r,
   input  logic [66:0]       rd_data_d,
   output logic              rd_data_r,
   output logic [66:0]       o_QTree_Int_tdata,
   output logic              o_QTree_Int_tlast,
   output logic              o_QTree_Int_tvalid,
   input  logic              o_QTree_Int_tready,
   output logic              overflow,
   output logic              busy
);
   localparam int SP_W = $clog2(STACK_DEPTH) + 1;
   localparam int IW   = SP_W - 1;
   localparam logic [66:0] NODE_TOK = {64'd0, 2'd2, 1'b1};

   typedef enum logic [2:0] {IDLE, POP, RD_REQ, RD_WAIT, PUSH, EMIT} state_t;

   state_t            state, nxt;
   logic [SP_W-1:0]   sp;
   logic [ADDR_W:0]   stk [STACK_DEPTH];
   logic [ADDR_W-1:0] addr;
   logic [63:0]       kids;
   logic [66:0]       tok;
   logic [2:0]        pcnt;
   logic              ovf, rdy;
   logic              empty, full, acc, do_push;
   logic [IW-1:0]     top_idx;
   logic [ADDR_W:0]   top, push_e, child_e;

   assign empty   = sp == '0;
   assign full    = sp == SP_W'(STACK_DEPTH);
   assign acc     = state == IDLE && rdy && root_d[0];
   assign do_push = acc || state == PUSH;
   assign top_idx = sp[IW-1:0] - IW'(1);
   assign top     = stk[top_idx];
   // marker first so it sits beneath the children; c0 ends up on top
   assign child_e = pcnt == 3'd1 ? {1'b0, ADDR_W'(kids[63:48])} :
                    pcnt == 3'd2 ? {1'b0, ADDR_W'(kids[47:32])} :
                    pcnt == 3'd3 ? {1'b0, ADDR_W'(kids[31:16])} :
                                   {1'b0, ADDR_W'(kids[15:0])};
   assign push_e  = state == IDLE ? {1'b0, root_d[ADDR_W:1]} :
                    pcnt == 3'd0  ? {1'b1, addr} : child_e;

   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         state <= IDLE;
         sp    <= '0;
         ovf   <= 1'b0;
         rdy   <= 1'b0;
         pcnt  <= '0;
         addr  <= '0;
         kids  <= '0;
         tok   <= '0;
      end else begin
         state <= nxt;
         rdy   <= nxt == IDLE;
         pcnt  <= state == PUSH ? pcnt + 3'd1 : 3'd0;
         if (do_push && full) begin
            ovf <= 1'b1;
            sp  <= '0;
         end else if (do_push)
            sp <= sp + SP_W'(1);
         else if (state == POP && !empty)
            sp <= sp - SP_W'(1);
         if (state == POP && !empty) begin
            addr <= top[ADDR_W-1:0];
            tok  <= NODE_TOK;
         end
         if (state == RD_WAIT && rd_data_d[0]) begin
            kids <= rd_data_d[66:3];
            tok  <= rd_data_d | 67'd1;
         end
      end
   end

   always_ff @(posedge clk)
      if (do_push && !full) stk[sp[IW-1:0]] <= push_e;

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = acc ? POP : IDLE;
         POP:     nxt = empty ? IDLE : top[ADDR_W] ? EMIT : RD_REQ;
         RD_REQ:  nxt = rd_addr_r ? RD_WAIT : RD_REQ;
         RD_WAIT: nxt = !rd_data_d[0] ? RD_WAIT : rd_data_d[2:1] == 2'd2 ? PUSH : EMIT;
         PUSH:    nxt = full ? IDLE : pcnt == 3'd4 ? POP : PUSH;
         EMIT:    nxt = o_QTree_Int_tready ? POP : EMIT;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      root_r             = rdy;
      rd_addr_d          = {addr, state == RD_REQ};
      rd_data_r          = state == RD_WAIT;
      o_QTree_Int_tvalid = state == EMIT;
      o_QTree_Int_tlast  = state == EMIT && empty;
      o_QTree_Int_tdata  = tok;
      overflow           = ovf;
      busy               = state != IDLE;
   end
endmodule

// File: tb/tb_qtree_int_stream_tx.sv
// tb_qtree_int_stream_tx: directed trees against a heap model; expected tokens
// are queued at stimulus time and a monitor pops them on each handshake.
module tb_qtree_int_stream_tx;
   logic clk = 1'b0;
   logic aresetn = 1'b1;
   always #5 clk = ~clk;

   logic [16:0] root_d1, root_d2, rd_addr_d1, rd_addr_d2;
   logic        root_r1, root_r2, rd_addr_r1, rd_addr_r2, rd_data_r1, rd_data_r2;
   logic [66:0] rd_data_d1, rd_data_d2, tdata1, tdata2;
   logic        tlast1, tlast2, tvalid1, tvalid2, tready1, tready2;
   logic        overflow1, overflow2, busy1, busy2;

   qtree_int_stream_tx #(.ADDR_W(16), .STACK_DEPTH(256)) dut1 (
      .clk(clk), .aresetn(aresetn), .root_d(root_d1), .root_r(root_r1),
      .rd_addr_d(rd_addr_d1), .rd_addr_r(rd_addr_r1), .rd_data_d(rd_data_d1),
      .rd_data_r(rd_data_r1), .o_QTree_Int_tdata(tdata1), .o_QTree_Int_tlast(tlast1),
      .o_QTree_Int_tvalid(tvalid1), .o_QTree_Int_tready(tready1),
      .overflow(overflow1), .busy(busy1));

   qtree_int_stream_tx #(.ADDR_W(16), .STACK_DEPTH(4)) dut2 (
      .clk(clk), .aresetn(aresetn), .root_d(root_d2), .root_r(root_r2),
      .rd_addr_d(rd_addr_d2), .rd_addr_r(rd_addr_r2), .rd_data_d(rd_data_d2),
      .rd_data_r(rd_data_r2), .o_QTree_Int_tdata(tdata2), .o_QTree_Int_tlast(tlast2),
      .o_QTree_Int_tvalid(tvalid2), .o_QTree_Int_tready(tready2),
      .overflow(overflow2), .busy(busy2));

   int checks = 0;
   int errors = 0;
   int mode = 0;
   int lat_max = 0;
   logic [66:0] mem [0:63];
   logic [67:0] q1[$], q2[$];

   function automatic logic [66:0] qv(input logic [31:0] v);
      return {32'd0, v, 2'd1, 1'b0};
   endfunction
   function automatic logic [66:0] qn(input logic [15:0] c0, c1, c2, c3);
      return {c3, c2, c1, c0, 2'd2, 1'b0};
   endfunction
   localparam logic [66:0] NTOK = {64'd0, 2'd2, 1'b1};

   // heap for dut1: random 0..lat_max cycle latency
   logic pend1, pend2;
   int cnt1;
   logic [66:0] word1, word2;
   assign rd_addr_r1 = !pend1;
   assign rd_data_d1 = (pend1 && cnt1 == 0) ? (word1 | 67'd1) : '0;
   always @(posedge clk or negedge aresetn)
      if (!aresetn) begin
         pend1 <= 1'b0;
         cnt1 <= 0;
      end else if (!pend1) begin
         if (rd_addr_d1[0]) begin
            pend1 <= 1'b1;
            cnt1 <= int'($urandom_range(0, lat_max));
            word1 <= mem[rd_addr_d1[6:1]];
         end
      end else if (cnt1 > 0) cnt1 <= cnt1 - 1;
      else if (rd_data_r1) pend1 <= 1'b0;

   // heap for dut2: zero latency
   assign rd_addr_r2 = !pend2;
   assign rd_data_d2 = pend2 ? (word2 | 67'd1) : '0;
   always @(posedge clk or negedge aresetn)
      if (!aresetn) pend2 <= 1'b0;
      else if (!pend2) begin
         if (rd_addr_d2[0]) begin
            pend2 <= 1'b1;
            word2 <= mem[rd_addr_d2[6:1]];
         end
      end else if (rd_data_r2) pend2 <= 1'b0;

   initial begin
      tready1 = 1'b1;
      tready2 = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         tready1 = mode == 0 ? 1'b1 : mode == 1 ? 1'b0 : 1'($urandom_range(0, 1));
      end
   end

   logic stall1 = 1'b0;
   logic [67:0] hold1;
   always @(negedge clk) begin
      if (!aresetn) stall1 = 1'b0;
      else begin
         if (stall1 && tvalid1) begin
            checks++;
            if ({tlast1, tdata1} !== hold1) begin
               errors++;
               $display("FAIL stall_hold got %h expected %h", {tlast1, tdata1}, hold1);
            end
         end
         if (tvalid1 && tready1) begin
            checks++;
            if (q1.size() == 0) begin
               errors++;
               $display("FAIL tok1 unexpected got %h expected none", {tlast1, tdata1});
            end else begin
               logic [67:0] e;
               e = q1.pop_front();
               if ({tlast1, tdata1} !== e) begin
                  errors++;
                  $display("FAIL tok1 got %h expected %h", {tlast1, tdata1}, e);
               end
            end
         end
         stall1 = tvalid1 && !tready1;
         hold1 = {tlast1, tdata1};
      end
   end

   always @(negedge clk)
      if (aresetn && tvalid2 && tready2) begin
         checks++;
         if (q2.size() == 0) begin
            errors++;
            $display("FAIL tok2 unexpected got %h expected none", {tlast2, tdata2});
         end else begin
            logic [67:0] e;
            e = q2.pop_front();
            if ({tlast2, tdata2} !== e) begin
               errors++;
               $display("FAIL tok2 got %h expected %h", {tlast2, tdata2}, e);
            end
         end
      end

   task automatic chk(input string n, input logic [67:0] got, input logic [67:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", n, got, exp);
      end
   endtask

   task automatic start(input int w, input logic [15:0] a);
      int n = 0;
      @(negedge clk);
      while (!(w == 1 ? root_r1 : root_r2) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("root_r_wait", {67'd0, w == 1 ? root_r1 : root_r2}, 68'd1);
      if (w == 1) root_d1 = {a, 1'b1};
      else root_d2 = {a, 1'b1};
      @(posedge clk);
      #1;
      root_d1 = '0;
      root_d2 = '0;
   endtask

   task automatic wait_done(input int w);
      int n = 0;
      while (n < 3000 && (w == 1 ? (busy1 || q1.size() != 0) : (busy2 || q2.size() != 0))) begin
         @(negedge clk);
         n++;
      end
      chk("done_timeout", {67'd0, n < 3000}, 68'd1);
   endtask

   task automatic push_one_node();
      q1.push_back({1'b0, qv(10) | 67'd1});
      q1.push_back({1'b0, qv(11) | 67'd1});
      q1.push_back({1'b0, qv(12) | 67'd1});
      q1.push_back({1'b0, qv(13) | 67'd1});
      q1.push_back({1'b1, NTOK});
   endtask

   task automatic push_two_level();
      q1.push_back({1'b0, mem[12] | 67'd1});
      q1.push_back({1'b0, mem[13] | 67'd1});
      q1.push_back({1'b0, mem[14] | 67'd1});
      q1.push_back({1'b0, mem[15] | 67'd1});
      q1.push_back({1'b0, NTOK});
      q1.push_back({1'b0, qv(10) | 67'd1});
      q1.push_back({1'b0, qv(11) | 67'd1});
      q1.push_back({1'b0, qv(12) | 67'd1});
      q1.push_back({1'b1, NTOK});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n;
      root_d1 = '0;
      root_d2 = '0;
      for (int i = 0; i < 64; i++) mem[i] = '0;
      mem[5]  = qv(42);
      mem[1]  = qn(2, 3, 4, 5);
      mem[2]  = qv(10);
      mem[3]  = qv(11);
      mem[4]  = qv(12);
      mem[10] = qn(11, 2, 3, 4);
      mem[11] = qn(12, 13, 14, 15);
      mem[12] = {64'd0, 2'd0, 1'b0};
      mem[13] = {64'd0, 2'd0, 1'b0};
      mem[14] = {64'hA5A5_0F0F_1234_5678, 2'd0, 1'b0};
      mem[15] = {64'd0, 2'd0, 1'b0};
      mem[20] = {32'hDEAD_BEEF, 32'h1234_5678, 2'd3, 1'b0};
      #2 aresetn = 1'b0;
      #1;
      chk("rst_root_r", {67'd0, root_r1}, 68'd0);
      chk("rst_rd_valid", {67'd0, rd_addr_d1[0]}, 68'd0);
      chk("rst_tvalid", {67'd0, tvalid1}, 68'd0);
      chk("rst_tlast", {67'd0, tlast1}, 68'd0);
      chk("rst_overflow", {67'd0, overflow1}, 68'd0);
      chk("rst_busy", {67'd0, busy1}, 68'd0);
      repeat (3) @(posedge clk);
      @(negedge clk) aresetn = 1'b1;
      @(negedge clk);
      chk("root_r_after_rst", {67'd0, root_r1}, 68'd1);

      // leaf root with latency checks
      q1.push_back({1'b1, qv(42) | 67'd1});
      start(1, 16'd5);
      chk("lat_pop_no_req", {67'd0, rd_addr_d1[0]}, 68'd0);
      @(posedge clk) #1;
      chk("lat_rd_req", {51'd0, rd_addr_d1}, {51'd0, 16'd5, 1'b1});
      @(posedge clk) #1;
      chk("lat_rd_wait", {67'd0, tvalid1}, 68'd0);
      @(posedge clk) #1;
      chk("lat_emit", {67'd0, tvalid1}, 68'd1);
      wait_done(1);
      chk("leaf_idle", {67'd0, busy1}, 68'd0);

      mem[5] = qv(13);
      push_one_node();
      start(1, 16'd1);
      wait_done(1);

      push_two_level();
      start(1, 16'd10);
      wait_done(1);

      q1.push_back({1'b1, mem[20] | 67'd1});
      start(1, 16'd20);
      wait_done(1);

      mode = 2;
      lat_max = 3;
      push_two_level();
      start(1, 16'd10);
      wait_done(1);
      push_one_node();
      start(1, 16'd1);
      wait_done(1);
      mode = 0;
      lat_max = 0;

      // reset while the first token of a node is stalled
      mode = 1;
      tready1 = 1'b0;
      start(1, 16'd1);
      n = 0;
      while (!tvalid1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("mid_tvalid_seen", {67'd0, tvalid1}, 68'd1);
      @(negedge clk) aresetn = 1'b0;
      #1;
      chk("mid_rst_tvalid", {67'd0, tvalid1}, 68'd0);
      chk("mid_rst_busy", {67'd0, busy1}, 68'd0);
      chk("mid_rst_rd_valid", {67'd0, rd_addr_d1[0]}, 68'd0);
      chk("mid_rst_root_r", {67'd0, root_r1}, 68'd0);
      repeat (2) @(negedge clk);
      aresetn = 1'b1;
      mode = 0;
      push_one_node();
      start(1, 16'd1);
      wait_done(1);

      // tiny stack overflows on a single QNode root
      start(2, 16'd1);
      wait_done(2);
      chk("ovf_set", {67'd0, overflow2}, 68'd1);
      chk("ovf_idle", {67'd0, busy2}, 68'd0);
      q2.push_back({1'b1, qv(11) | 67'd1});
      start(2, 16'd3);
      wait_done(2);
      chk("ovf_sticky", {67'd0, overflow2}, 68'd1);
      chk("no_ovf_big", {67'd0, overflow1}, 68'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
